// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - on-the-fly AES-128 round-key generator, one round key per clock
// Optional AES_KS_LAST_KEY_EN adds a last_key output holding the most recent round-10 key.
module aes_ks_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = gf_mul(x, x);
    r = p;
    for (int i = 0; i < 6; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv  = gf_inv(din);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_schedule #(
  parameter int           NR        = 10,
  parameter logic [127:0] RESET_KEY = 128'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_cnt,
  output logic         last,
  output logic         busy
`ifdef AES_KS_LAST_KEY_EN
  ,
  output logic [127:0] last_key
`endif
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_schedule: only NR = 10 is supported");
  end

  localparam logic [3:0] ST_IDLE = 4'(NR);

  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] next_key;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w;
  logic [31:0]  t, w0n, w1n, w2n, w3n;

  assign rot_w3 = {key_q[23:0], key_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_ks_sbox u_sbox (
      .din  (rot_w3[8*g +: 8]),
      .dout (sub_w[8*g +: 8])
    );
  end

  always_comb begin
    t        = sub_w ^ {rcon_q, 24'h0};
    w0n      = key_q[127:96] ^ t;
    w1n      = key_q[95:64] ^ w0n;
    w2n      = key_q[63:32] ^ w1n;
    w3n      = key_q[31:0] ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  // load wins over expansion so a restart never inherits the old key or rcon.
  always_comb begin
    key_d  = key_q;
    rcon_d = rcon_q;
    cnt_d  = cnt_q;
    if (load) begin
      key_d  = key_in;
      rcon_d = 8'h01;
      cnt_d  = 4'd0;
    end else if (cnt_q < ST_IDLE) begin
      key_d  = next_key;
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= RESET_KEY;
      rcon_q <= 8'h01;
      cnt_q  <= ST_IDLE;
    end else begin
      key_q  <= key_d;
      rcon_q <= rcon_d;
      cnt_q  <= cnt_d;
    end
  end

  assign round_key = key_q;
  assign round_cnt = cnt_q;
  assign last      = (cnt_q == ST_IDLE);
  assign busy      = (cnt_q < ST_IDLE);

`ifdef AES_KS_LAST_KEY_EN
  logic [127:0] last_key_q, last_key_d;

  always_comb begin
    last_key_d = last_key_q;
    if (!load && cnt_q == ST_IDLE - 4'd1) last_key_d = next_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_key_q <= 128'h0;
    else        last_key_q <= last_key_d;
  end

  assign last_key = last_key_q;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule against FIPS-197 vectors
// Define AES_KS_LAST_KEY_EN for both bench and design to cover the last_key output.
module tb_aes_key_schedule;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_cnt;
  logic         last;
  logic         busy;
`ifdef AES_KS_LAST_KEY_EN
  logic [127:0] last_key;
`endif

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .key_in    (key_in),
    .round_key (round_key),
    .round_cnt (round_cnt),
    .last      (last),
    .busy      (busy)
`ifdef AES_KS_LAST_KEY_EN
    ,
    .last_key  (last_key)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   cnt;
    logic [127:0] lk;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] m_key;
  logic [7:0]   m_rcon;
  logic [3:0]   m_cnt;
  logic [127:0] m_lk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w[4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    t = {sbox_ref(w[3][23:16]) ^ rc, sbox_ref(w[3][15:8]), sbox_ref(w[3][7:0]),
         sbox_ref(w[3][31:24])};
    w[0] = w[0] ^ t;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic model_reset();
    m_key  = 128'h0;
    m_rcon = 8'h01;
    m_cnt  = 4'd10;
    m_lk   = 128'h0;
  endtask

  task automatic cycle(input logic ld, input logic [127:0] kin);
    exp_t         e;
    logic [127:0] nk;
    @(negedge clk);
    load   = ld;
    key_in = kin;
    if (ld) begin
      m_key  = kin;
      m_rcon = 8'h01;
      m_cnt  = 4'd0;
    end else if (m_cnt < 4'd10) begin
      nk = model_next(m_key, m_rcon);
      if (m_cnt == 4'd9) m_lk = nk;
      m_key  = nk;
      m_rcon = {m_rcon[6:0], 1'b0} ^ (m_rcon[7] ? 8'h1B : 8'h00);
      m_cnt  = m_cnt + 4'd1;
    end
    e.key = m_key;
    e.cnt = m_cnt;
    e.lk  = m_lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 128'(sb.size()), 128'd1);
    end else begin
      e = sb.pop_front();
      check("round_key", round_key, e.key);
      check("round_cnt", 128'(round_cnt), 128'(e.cnt));
      check("last", 128'(last), 128'(e.cnt == 4'd10));
      check("busy", 128'(busy), 128'(e.cnt < 4'd10));
`ifdef AES_KS_LAST_KEY_EN
      check("last_key", last_key, e.lk);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, key_in);
  endtask

  task automatic fips_run();
    cycle(1'b1, FIPS_KEY);
    check("fips_r0", round_key, FIPS_KEY);
    cycle(1'b0, 128'h0);
    check("fips_r1", round_key, FIPS_R1);
    cycle(1'b0, 128'h0);
    check("fips_r2", round_key, FIPS_R2);
    idle(7);
    check("fips_r9_busy", 128'(busy), 128'd1);
    idle(1);
    check("fips_r10", round_key, FIPS_R10);
    check("fips_r10_last", 128'(last), 128'd1);
    idle(3);
    check("fips_r10_hold", round_key, FIPS_R10);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    key_in = 128'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: reset key, count parked at 10.
    idle(20);
    check("reset_cnt", 128'(round_cnt), 128'd10);

    fips_run();
`ifdef AES_KS_LAST_KEY_EN
    check("last_key_fips", last_key, FIPS_R10);
`endif

    // Restart mid-expansion with the sequential key.
    cycle(1'b1, FIPS_KEY);
    idle(5);
    check("restart_at5", 128'(round_cnt), 128'd5);
    cycle(1'b1, SEQ_KEY);
    check("restart_cnt0", 128'(round_cnt), 128'd0);
    cycle(1'b0, 128'h0);
    check("seq_r1", round_key, SEQ_R1);
`ifdef AES_KS_LAST_KEY_EN
    check("last_key_kept", last_key, FIPS_R10);
`endif
    idle(9);
    check("seq_r10", round_key, SEQ_R10);
`ifdef AES_KS_LAST_KEY_EN
    check("last_key_seq", last_key, SEQ_R10);
`endif

    // load held high: count stays 0, key tracks key_in.
    cycle(1'b1, SEQ_KEY);
    cycle(1'b1, FIPS_KEY);
    cycle(1'b1, {$urandom, $urandom, $urandom, $urandom});
    idle(2);

    // Asynchronous reset in the middle of an expansion.
    cycle(1'b1, FIPS_KEY);
    idle(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_key", round_key, 128'h0);
    check("async_rst_cnt", 128'(round_cnt), 128'd10);
    check("async_rst_last", 128'(last), 128'd1);
    check("async_rst_busy", 128'(busy), 128'd0);
    model_reset();
    cycle(1'b0, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fips_run();

    // One expansion step per S-box input: byte b lands in w0 byte 2 after RotWord.
    for (int b = 0; b < 256; b++) begin
      cycle(1'b1, {120'h0, 8'(b)});
      cycle(1'b0, 128'h0);
      check($sformatf("sbox_%02h", b), 128'(round_key[127:96]),
            128'({8'h62, 8'h63, sbox_ref(8'(b)), 8'h63}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
